// File: rtl/uart_frame_parser.sv
// uart_frame_parser
//   Assembles 5-byte command frames (HDR, CMD, ADDR, DATA, CHK) from the UART
//   receiver byte stream. CHK is CMD+ADDR+DATA modulo 256. Good frames are
//   presented on a valid/ready output register. Checksum errors, inter-byte
//   timeouts and output overflow are reported as one-cycle pulses.
//
//   Handshake: cmd_vld rises with cmd/addr/data valid and holds them stable
//   until the cycle in which cmd_vld && cmd_rdy is sampled by a rising clk edge;
//   cmd_rdy has no effect while cmd_vld is low.
//
// Ports
//   clk      in   1  system clock
//   rst      in   1  asynchronous, active-high reset
//   rx_dout  in   8  received byte
//   rx_vld   in   1  one-cycle pulse, rx_dout valid
//   cmd_rdy  in   1  consumer ready
//   cmd_vld  out  1  frame held on cmd/addr/data
//   cmd      out  8  CMD field
//   addr     out  8  ADDR field
//   data     out  8  DATA field
//   err_chk  out  1  checksum mismatch pulse
//   err_tmo  out  1  inter-byte timeout pulse
//   err_ovf  out  1  good frame dropped because output still occupied
module uart_frame_parser #(
    parameter logic [7:0] HDR     = 8'hA5,
    parameter int         TMO_CYC = 100000,
    parameter int         TMO_W   = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_dout,
    input  logic       rx_vld,
    input  logic       cmd_rdy,
    output logic       cmd_vld,
    output logic [7:0] cmd,
    output logic [7:0] addr,
    output logic [7:0] data,
    output logic       err_chk,
    output logic       err_tmo,
    output logic       err_ovf
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        S_CMD  = 3'd1,
        S_ADDR = 3'd2,
        S_DATA = 3'd3,
        S_CHK  = 3'd4
    } state_t;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    state_t           state;
    state_t           state_next;
    logic [TMO_W-1:0] tmo_cnt;
    logic [7:0]       sum;
    logic [7:0]       cmd_s;
    logic [7:0]       addr_s;
    logic [7:0]       data_s;
    logic             tmo_hit;
    logic             chk_good;
    logic             chk_bad;
    logic             load;
    logic             ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        // A byte arriving in the terminal cycle suppresses the timeout.
        tmo_hit    = (state != IDLE) && !rx_vld && (tmo_cnt == TMO_LAST);
        chk_good   = (state == S_CHK) && rx_vld && (rx_dout == sum);
        chk_bad    = (state == S_CHK) && rx_vld && (rx_dout != sum);
        // The slot is free if empty or being drained in this very cycle.
        load       = chk_good && (!cmd_vld || cmd_rdy);
        ovf        = chk_good && cmd_vld && !cmd_rdy;
        if (tmo_hit) begin
            state_next = IDLE;
        end else if (rx_vld) begin
            case (state)
                IDLE:    state_next = (rx_dout == HDR) ? S_CMD : IDLE;
                S_CMD:   state_next = S_ADDR;
                S_ADDR:  state_next = S_DATA;
                S_DATA:  state_next = S_CHK;
                S_CHK:   state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Inter-byte timeout counter; idle outside a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state == IDLE || rx_vld || tmo_hit) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Shadow registers and running checksum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum    <= 8'h00;
            cmd_s  <= 8'h00;
            addr_s <= 8'h00;
            data_s <= 8'h00;
        end else if (rx_vld) begin
            case (state)
                IDLE: if (rx_dout == HDR) sum <= 8'h00;
                S_CMD: begin
                    cmd_s <= rx_dout;
                    sum   <= sum + rx_dout;
                end
                S_ADDR: begin
                    addr_s <= rx_dout;
                    sum    <= sum + rx_dout;
                end
                S_DATA: begin
                    data_s <= rx_dout;
                    sum    <= sum + rx_dout;
                end
                default: ;
            endcase
        end
    end

    // Output register and error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_vld <= 1'b0;
            cmd     <= 8'h00;
            addr    <= 8'h00;
            data    <= 8'h00;
            err_chk <= 1'b0;
            err_tmo <= 1'b0;
            err_ovf <= 1'b0;
        end else begin
            if (load) begin
                cmd_vld <= 1'b1;
                cmd     <= cmd_s;
                addr    <= addr_s;
                data    <= data_s;
            end else if (cmd_rdy) begin
                cmd_vld <= 1'b0;
            end
            err_chk <= chk_bad;
            err_tmo <= tmo_hit;
            err_ovf <= ovf;
        end
    end

endmodule
